board_matrix: RTL



---
 rtl/board_pkg.sv | 31 +++
 rtl/board_matrix_if.sv | 40 ++++
 rtl/board_array.sv | 55 +++++
 rtl/board_matrix.sv | 121 ++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and helpers for the two-board battleship matrix.
//   cell_t  : per-cell 2-bit code (guest UNKNOWN shares the EMPTY encoding)
//   phase_t : game phase driven by the board_matrix FSM
//   RESP_*  : shot response codes returned to the opponent
//   in_range: coordinate bounds check against the board size
package board_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    PH_PLACE = 2'b00,
    PH_ARMED = 2'b01,
    PH_SUNK  = 2'b10
  } phase_t;

  localparam logic [1:0] RESP_INVALID = 2'b00;
  localparam logic [1:0] RESP_HIT     = 2'b10;
  localparam logic [1:0] RESP_MISS    = 2'b11;

  // Coordinates are widened to 16 bits by the caller so one helper serves any COORD_W.
  function automatic logic in_range(input logic [15:0] x, input logic [15:0] y,
                                    input logic [15:0] n);
    return (x < n) && (y < n);
  endfunction

endpackage

// File: rtl/board_matrix_if.sv
// Game-control / renderer bus of board_matrix.
//   master : game logic + renderers (drive requests and read addresses)
//   slave  : board_matrix (drives pulses, responses, read data, status)
interface board_matrix_if #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 4
);
  logic               clear;
  logic               place_valid, place_ready, place_ok, place_err;
  logic [COORD_W-1:0] place_x, place_y;
  logic               shot_in_valid, shot_in_ready, shot_resp_valid;
  logic [COORD_W-1:0] shot_in_x, shot_in_y;
  logic [1:0]         shot_resp;
  logic               result_valid;
  logic [COORD_W-1:0] result_x, result_y;
  logic [1:0]         result_code;
  logic [COORD_W-1:0] rd_host_x, rd_host_y, rd_guest_x, rd_guest_y;
  logic [1:0]         rd_host_code, rd_guest_code;
  logic [1:0]         phase;
  logic [CNT_W-1:0]   ships_placed, ships_left;
  logic               fleet_sunk;

  modport master (
    output clear, place_valid, place_x, place_y,
           shot_in_valid, shot_in_x, shot_in_y,
           result_valid, result_x, result_y, result_code,
           rd_host_x, rd_host_y, rd_guest_x, rd_guest_y,
    input  place_ready, place_ok, place_err, shot_in_ready, shot_resp_valid, shot_resp,
           rd_host_code, rd_guest_code, phase, ships_placed, ships_left, fleet_sunk
  );

  modport slave (
    input  clear, place_valid, place_x, place_y,
           shot_in_valid, shot_in_x, shot_in_y,
           result_valid, result_x, result_y, result_code,
           rd_host_x, rd_host_y, rd_guest_x, rd_guest_y,
    output place_ready, place_ok, place_err, shot_in_ready, shot_resp_valid, shot_resp,
           rd_host_code, rd_guest_code, phase, ships_placed, ships_left, fleet_sunk
  );
endinterface

// File: rtl/board_array.sv
// BOARD_SIZE x BOARD_SIZE array of 2-bit cells.
//   i_we/i_wx/i_wy/i_wcode : single write port
//   i_rx/i_ry -> o_rcode   : registered read port (1-cycle latency)
//   i_lx/i_ly -> o_lcode   : combinational lookup port
//   i_clear                : synchronous clear (wins over a write)
// Out-of-range addresses read as 00 and never write.
module board_array #(
  parameter int BOARD_SIZE = 10,
  parameter int COORD_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_we,
  input  logic [COORD_W-1:0] i_wx,
  input  logic [COORD_W-1:0] i_wy,
  input  logic [1:0]         i_wcode,
  input  logic [COORD_W-1:0] i_rx,
  input  logic [COORD_W-1:0] i_ry,
  output logic [1:0]         o_rcode,
  input  logic [COORD_W-1:0] i_lx,
  input  logic [COORD_W-1:0] i_ly,
  output logic [1:0]         o_lcode
);
  logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0][1:0] r_mem;
  logic [1:0] r_rcode, w_rcode;

  // Address decode by compare keeps arbitrary BOARD_SIZE/COORD_W combinations in bounds.
  always_comb begin
    w_rcode = 2'b00;
    o_lcode = 2'b00;
    for (int y = 0; y < BOARD_SIZE; y++)
      for (int x = 0; x < BOARD_SIZE; x++) begin
        if (i_rx == COORD_W'(x) && i_ry == COORD_W'(y)) w_rcode = r_mem[y][x];
        if (i_lx == COORD_W'(x) && i_ly == COORD_W'(y)) o_lcode = r_mem[y][x];
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_rcode <= 2'b00;
    end else if (i_clear) begin
      r_mem   <= '0;
      r_rcode <= 2'b00;
    end else begin
      for (int y = 0; y < BOARD_SIZE; y++)
        for (int x = 0; x < BOARD_SIZE; x++)
          if (i_we && i_wx == COORD_W'(x) && i_wy == COORD_W'(y)) r_mem[y][x] <= i_wcode;
      r_rcode <= w_rcode;
    end
  end

  assign o_rcode = r_rcode;
endmodule

// File: rtl/board_matrix.sv
// Two-board battleship matrix: host board (own fleet + opponent shots) and
// guest board (outcome of our shots), with phase FSM PLACE -> ARMED -> SUNK.
//   clk, rst_n : clock, async active-low reset
//   bus        : board_matrix_if.slave (placement, opponent shots, shot results,
//                renderer read ports, phase and fleet counters)
module board_matrix
  import board_pkg::*;
#(
  parameter int BOARD_SIZE = 10,
  parameter int COORD_W    = 4,
  parameter int SHIP_TOTAL = 10,
  parameter int CNT_W      = $clog2(SHIP_TOTAL + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  board_matrix_if.slave  bus
);
  phase_t             r_phase;
  logic               r_place_ok, r_place_err, r_resp_vld;
  logic [1:0]         r_resp;
  logic [CNT_W-1:0]   r_placed, r_left;

  logic               w_shot_ready, w_shot_fire, w_shot_inr, w_place_fire, w_place_good, w_res_good;
  logic [COORD_W-1:0] w_lk_x, w_lk_y;
  logic [1:0]         w_lk_code, w_h_code;
  logic               w_h_we;

  assign w_shot_ready = (r_phase == PH_ARMED) && !r_resp_vld;
  assign w_shot_fire  = bus.shot_in_valid && w_shot_ready;
  assign w_shot_inr   = in_range(16'(bus.shot_in_x), 16'(bus.shot_in_y), 16'(BOARD_SIZE));

  // Placement and shots live in disjoint phases, so they share the host lookup/write address.
  assign w_lk_x = (r_phase == PH_PLACE) ? bus.place_x : bus.shot_in_x;
  assign w_lk_y = (r_phase == PH_PLACE) ? bus.place_y : bus.shot_in_y;

  assign w_place_fire = (r_phase == PH_PLACE) && bus.place_valid;
  assign w_place_good = in_range(16'(bus.place_x), 16'(bus.place_y), 16'(BOARD_SIZE))
                        && (w_lk_code == CELL_EMPTY);

  assign w_res_good = (r_phase == PH_ARMED) && bus.result_valid
                      && in_range(16'(bus.result_x), 16'(bus.result_y), 16'(BOARD_SIZE))
                      && (bus.result_code == RESP_HIT || bus.result_code == RESP_MISS);

  always_comb begin
    w_h_we   = 1'b0;
    w_h_code = CELL_SHIP;
    if (w_place_fire && w_place_good) begin
      w_h_we = 1'b1;
    end else if (w_shot_fire && w_shot_inr && w_lk_code == CELL_SHIP) begin
      w_h_we   = 1'b1;
      w_h_code = CELL_HIT;
    end else if (w_shot_fire && w_shot_inr && w_lk_code == CELL_EMPTY) begin
      w_h_we   = 1'b1;
      w_h_code = CELL_MISS;
    end
  end

  board_array #(.BOARD_SIZE(BOARD_SIZE), .COORD_W(COORD_W)) u_host (
    .clk(clk), .rst_n(rst_n), .i_clear(bus.clear),
    .i_we(w_h_we), .i_wx(w_lk_x), .i_wy(w_lk_y), .i_wcode(w_h_code),
    .i_rx(bus.rd_host_x), .i_ry(bus.rd_host_y), .o_rcode(bus.rd_host_code),
    .i_lx(w_lk_x), .i_ly(w_lk_y), .o_lcode(w_lk_code)
  );

  logic [1:0] w_g_unused;
  board_array #(.BOARD_SIZE(BOARD_SIZE), .COORD_W(COORD_W)) u_guest (
    .clk(clk), .rst_n(rst_n), .i_clear(bus.clear),
    .i_we(w_res_good), .i_wx(bus.result_x), .i_wy(bus.result_y), .i_wcode(bus.result_code),
    .i_rx(bus.rd_guest_x), .i_ry(bus.rd_guest_y), .o_rcode(bus.rd_guest_code),
    .i_lx(bus.result_x), .i_ly(bus.result_y), .o_lcode(w_g_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_PLACE; r_place_ok <= 1'b0; r_place_err <= 1'b0;
      r_resp_vld <= 1'b0; r_resp <= RESP_INVALID; r_placed <= '0; r_left <= '0;
    end else if (bus.clear) begin
      r_phase <= PH_PLACE; r_place_ok <= 1'b0; r_place_err <= 1'b0;
      r_resp_vld <= 1'b0; r_resp <= RESP_INVALID; r_placed <= '0; r_left <= '0;
    end else begin
      r_place_ok  <= 1'b0;
      r_place_err <= 1'b0;
      r_resp_vld  <= 1'b0;
      case (r_phase)
        PH_PLACE: if (bus.place_valid) begin
          if (w_place_good) begin
            r_place_ok <= 1'b1;
            if (r_placed != CNT_W'(SHIP_TOTAL)) r_placed <= r_placed + 1'b1;
            if (r_left   != CNT_W'(SHIP_TOTAL)) r_left   <= r_left + 1'b1;
            if (r_placed == CNT_W'(SHIP_TOTAL - 1)) r_phase <= PH_ARMED;
          end else begin
            r_place_err <= 1'b1;
          end
        end
        PH_ARMED: if (w_shot_fire) begin
          r_resp_vld <= 1'b1;
          r_resp     <= RESP_INVALID;
          if (w_shot_inr && w_lk_code == CELL_SHIP) begin
            r_resp <= RESP_HIT;
            if (r_left != '0) r_left <= r_left - 1'b1;
            if (r_left == CNT_W'(1)) r_phase <= PH_SUNK;
          end else if (w_shot_inr && w_lk_code == CELL_EMPTY) begin
            r_resp <= RESP_MISS;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.place_ready     = (r_phase == PH_PLACE);
  assign bus.place_ok        = r_place_ok;
  assign bus.place_err       = r_place_err;
  assign bus.shot_in_ready   = w_shot_ready;
  assign bus.shot_resp_valid = r_resp_vld;
  assign bus.shot_resp       = r_resp;
  assign bus.phase           = r_phase;
  assign bus.ships_placed    = r_placed;
  assign bus.ships_left      = r_left;
  assign bus.fleet_sunk      = (r_phase == PH_SUNK);
endmodule
